buffer_reader: RTL



---
 rtl/buffer_reader_if.sv | 29 ++
 rtl/buffer_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/buffer_reader_if.sv
// Signal bundle between buffer_reader, the word buffer read port, the
// transfer requester and the downstream valid/ready consumer.
interface buffer_reader_if #(
    parameter int unsigned WWORD = 32,
    parameter int unsigned AW    = 12
);
    logic             start;
    logic [AW-1:0]    base;
    logic [AW-1:0]    len;
    logic             busy;
    logic             done;
    logic             err;
    logic [AW-1:0]    mem_a;
    logic             mem_cen;
    logic [WWORD-1:0] mem_q;
    logic [WWORD-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  start, base, len, mem_q, out_ready,
        output busy, done, err, mem_a, mem_cen, out_data, out_valid
    );

    modport slave (
        output start, base, len, mem_q, out_ready,
        input  busy, done, err, mem_a, mem_cen, out_data, out_valid
    );
endinterface

// File: rtl/buffer_reader.sv
// Streams a circular window of words out of the on-chip buffer, hiding the
// buffer's one-cycle read latency behind a 2-entry return FIFO.
module buffer_reader #(
    parameter int unsigned WWORD = 32,
    parameter int unsigned DEPTH = 24,
    parameter int unsigned AW    = 12
) (
    input  logic             clk,
    input  logic             rstn,
    buffer_reader_if.master  bus
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [AW-1:0]    addr;
    logic [AW-1:0]    issue_left;
    logic [AW-1:0]    beat_left;
    logic             inflight;
    logic [1:0]       fifo_count;
    logic [WWORD-1:0] fifo_q0;
    logic [WWORD-1:0] fifo_q1;

    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             busy_nxt;
    logic             done_nxt;
    logic             err_nxt;

    logic             issue;
    logic             accept;
    logic             pop;
    logic             push;
    logic [2:0]       occ;

    assign pop  = (fifo_count != 2'd0) && bus.out_ready;
    assign push = inflight;
    // Occupancy seen by the issue rule: buffered plus in flight, after this cycle's pop.
    assign occ  = 3'(fifo_count) + 3'(inflight) - 3'(pop);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, read issue and status pulses.
    always_comb begin
        state_nxt = state;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.base >= DEPTH_A) || (bus.len > DEPTH_A)) begin
                        err_nxt = 1'b1;
                    end else if (bus.len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        busy_nxt  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (occ < 3'd2) begin
                    issue = 1'b1;
                    if (issue_left == AW'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (beat_left == AW'(1))) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    // Address walk and transfer counters; addr stays on the last issued address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr       <= '0;
            issue_left <= '0;
            beat_left  <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept) begin
                addr       <= bus.base;
                issue_left <= bus.len;
                beat_left  <= bus.len;
            end else begin
                if (issue) begin
                    issue_left <= issue_left - AW'(1);
                    if (issue_left != AW'(1)) begin
                        addr <= (addr == LAST_A) ? '0 : addr + AW'(1);
                    end
                end
                if (pop) begin
                    beat_left <= beat_left - AW'(1);
                end
            end
        end
    end

    // Return FIFO: fifo_q0 is always the head, so out_data comes straight from a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fifo_count <= 2'd0;
            fifo_q0    <= '0;
            fifo_q1    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        fifo_q0 <= bus.mem_q;
                    end else begin
                        fifo_q1 <= bus.mem_q;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_q0    <= fifo_q1;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_q0 <= bus.mem_q;
                    end else begin
                        fifo_q0 <= fifo_q1;
                        fifo_q1 <= bus.mem_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_cen   = ~issue;
    assign bus.mem_a     = addr;
    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = fifo_q0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    a_fifo_bound : assert property (@(posedge clk) disable iff (!rstn) fifo_count <= 2'd2);
    a_addr_range : assert property (@(posedge clk) disable iff (!rstn) !issue || (addr < DEPTH_A));

endmodule
